// File: rtl/versat_div.sv
// versat_div: Versat functional unit performing signed truncating division.
// Uses the same run/done, delay0, iterations and period configuration interface
// as the multiply-accumulate unit. One operand pair is sampled per period slot.
// A multi-cycle restoring divider then computes the result, and out0 holds the
// last completed result.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   run                 single-cycle start pulse; aborts any in-flight division
//   done                programmed run complete and divider idle
//   in0, in1            dividend / divisor (signed)
//   opcode              0 = quotient, 1 = remainder
//   out0                selected result, DATA_W+2 cycles after capture
//   overrun             sticky: a sample slot was missed because the divider was busy
//   iterations, period  number of periods / cycles per period (0 acts as 1)
//   delay0              start delay in cycles
module versat_div #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned PERIOD_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  done,
    input  logic [DATA_W-1:0]     in0,
    input  logic [DATA_W-1:0]     in1,
    output logic [DATA_W-1:0]     out0,
    output logic                  overrun,
    input  logic                  opcode,
    input  logic [MEM_ADDR_W-1:0] iterations,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [31:0]           delay0
);

    localparam int unsigned STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX
    } div_state_e;

    div_state_e              state_q, state_d;
    logic [31:0]             delay_q, delay_d;
    logic [PERIOD_W-1:0]     per_cnt_q, per_cnt_d;
    logic [MEM_ADDR_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic                    armed_q, armed_d;
    logic                    fin_q, fin_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_W-1:0]       out0_q, out0_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    fix_q, fix_d;
    logic [DATA_W-1:0]       quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]       rem_q, rem_d;
    logic [DATA_W-1:0]       dvs_q, dvs_d;
    logic [DATA_W-1:0]       res_q, res_d;
    logic                    q_neg_q, q_neg_d;
    logic                    r_neg_q, r_neg_d;
    logic                    op_q, op_d;
    logic                    dz_q, dz_d;

    logic [DATA_W-1:0]       a_mag, b_mag;
    logic [DATA_W:0]         rem_shift, rem_diff;
    logic [PERIOD_W-1:0]     per_last;
    logic                    div_free, active, slot;

    assign a_mag     = in0[DATA_W-1] ? ('0 - in0) : in0;
    assign b_mag     = in1[DATA_W-1] ? ('0 - in1) : in1;
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign per_last  = (period == '0) ? '0 : period - PERIOD_W'(1);

    // The divider accepts a new pair on the same edge that it publishes its result.
    assign div_free  = (state_q == DIV_IDLE) || ((state_q == DIV_FIX) && fix_q);
    assign active    = armed_q && (delay_q == '0) && !fin_q;
    assign slot      = active && (per_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        per_cnt_d  = per_cnt_q;
        iter_cnt_d = iter_cnt_q;
        armed_d    = armed_q;
        fin_d      = fin_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        out0_d     = out0_q;
        step_d     = step_q;
        fix_d      = fix_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        res_d      = res_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        op_d       = op_q;
        dz_d       = dz_q;

        if (run) begin
            delay_d    = delay0 + 32'd2;
            done_d     = 1'b0;
            overrun_d  = 1'b0;
            armed_d    = 1'b1;
            fin_d      = 1'b0;
            per_cnt_d  = '0;
            iter_cnt_d = '0;
            state_d    = DIV_IDLE;
            fix_d      = 1'b0;
        end else begin
            case (state_q)
                DIV_CALC: begin
                    if (!rem_diff[DATA_W]) begin
                        rem_d = rem_diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(DATA_W - 1)) begin
                        state_d = DIV_FIX;
                        fix_d   = 1'b0;
                    end
                end
                DIV_FIX: begin
                    // Remainder of a divide-by-zero is |in0| re-signed by in0, i.e. in0.
                    // Most-negative / -1 falls out naturally as in0 with remainder 0.
                    if (!fix_q) begin
                        if (op_q)
                            res_d = r_neg_q ? ('0 - rem_q) : rem_q;
                        else if (dz_q)
                            res_d = '1;
                        else
                            res_d = q_neg_q ? ('0 - quo_q) : quo_q;
                        fix_d = 1'b1;
                    end else begin
                        out0_d  = res_q;
                        state_d = DIV_IDLE;
                        fix_d   = 1'b0;
                    end
                end
                default: ;
            endcase

            if (delay_q != '0) begin
                delay_d    = delay_q - 32'd1;
                per_cnt_d  = '0;
                iter_cnt_d = '0;
                if (iterations == '0) begin
                    done_d = 1'b1;
                    fin_d  = 1'b1;
                end
            end else if (active) begin
                if (per_cnt_q == per_last) begin
                    per_cnt_d  = '0;
                    iter_cnt_d = iter_cnt_q + MEM_ADDR_W'(1);
                    if (({1'b0, iter_cnt_q} + (MEM_ADDR_W + 1)'(1)) >= {1'b0, iterations})
                        fin_d = 1'b1;
                end else begin
                    per_cnt_d = per_cnt_q + PERIOD_W'(1);
                end
            end

            if (slot) begin
                if (div_free) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    q_neg_d = in0[DATA_W-1] ^ in1[DATA_W-1];
                    r_neg_d = in0[DATA_W-1];
                    dz_d    = (in1 == '0);
                    op_d    = opcode;
                    step_d  = '0;
                    fix_d   = 1'b0;
                    state_d = DIV_CALC;
                end else begin
                    overrun_d = 1'b1;
                end
            end

            if (fin_q && (state_q == DIV_IDLE))
                done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            delay_q    <= '0;
            per_cnt_q  <= '0;
            iter_cnt_q <= '0;
            armed_q    <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            out0_q     <= '0;
            step_q     <= '0;
            fix_q      <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            res_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            op_q       <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            per_cnt_q  <= per_cnt_d;
            iter_cnt_q <= iter_cnt_d;
            armed_q    <= armed_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            out0_q     <= out0_d;
            step_q     <= step_d;
            fix_q      <= fix_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            res_q      <= res_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            op_q       <= op_d;
            dz_q       <= dz_d;
        end
    end

    assign done    = done_q;
    assign overrun = overrun_q;
    assign out0    = out0_q;

endmodule

// File: tb/tb_versat_div.sv
// tb_versat_div: self-checking bench for versat_div (DATA_W=32).
// Expected results come from plain signed arithmetic. Expected timing comes
// from the slot/latency rules evaluated per run.
module tb_versat_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        done;
    logic        overrun;
    logic        opcode = 1'b0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic [31:0] out0;
    logic [31:0] delay0 = '0;
    logic [9:0]  iterations = '0;
    logic [9:0]  period = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_ops = 1'b0;

    logic [31:0] log0 [1024];
    logic [31:0] log1 [1024];
    logic        logop [1024];

    versat_div #(.DATA_W(32), .MEM_ADDR_W(10), .PERIOD_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .done(done),
        .in0(in0), .in1(in1), .out0(out0), .overrun(overrun),
        .opcode(opcode), .iterations(iterations), .period(period), .delay0(delay0)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the most recent edge; log[n] is the input seen at edge n.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        log0[(cyc + 1) % 1024]  <= in0;
        log1[(cyc + 1) % 1024]  <= in1;
        logop[(cyc + 1) % 1024] <= opcode;
    end

    function automatic logic [31:0] rnd_dividend();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_divisor();
        logic [31:0] t;
        t = $urandom_range(1, 20);
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return t;
            3:       return 32'h0 - t;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rand_ops) begin
            in0    = rnd_dividend();
            in1    = rnd_divisor();
            opcode = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic op);
        int sa, sb, q, r;
        sa = a;
        sb = b;
        if (sb == 0) begin
            q = -1; r = sa;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            q = sa; r = 0;
        end else begin
            q = sa / sb; r = sa % sb;
        end
        return op ? 32'(r) : 32'(q);
    endfunction

    // Capture edges are first_slot + P*k; a slot is taken only if the previous
    // division has published (34 edges after its capture).
    task automatic model_run(input int s, input int it, input int p,
                             output int last, output bit ovr, output int done_e);
        int pp, c, f;
        pp = (p == 0) ? 1 : p;
        last = -1000;
        ovr = 1'b0;
        for (int k = 0; k < it; k++) begin
            c = s + pp * k;
            if (c - last >= 34) last = c;
            else ovr = 1'b1;
        end
        f = s + pp * it - 1;
        done_e = ((f > last + 34) ? f : last + 34) + 1;
    endtask

    task automatic pulse_run(input logic [31:0] d0, input logic [9:0] it, input logic [9:0] p, output int r);
        @(negedge clk);
        delay0 = d0; iterations = it; period = p; run = 1'b1;
        @(posedge clk);
        #1;
        r = cyc;
        run = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int limit, output int de);
        de = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                de = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (out0 !== 32'h0) begin bad++; $display("FAIL reset_out0: got %h want 0", out0); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_no_run_done: got %b want 0", done); end
    endtask

    task automatic test_one_div(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] old, exp;
        int r, s, de;
        rand_ops = 1'b0;
        @(negedge clk);
        in0 = a; in1 = b; opcode = op;
        old = out0;
        exp = ref_div(a, b, op);
        pulse_run(32'd0, 10'd1, 10'd40, r);
        s = r + 3;
        wait_edge(s + 33);
        total++; if (out0 !== old) begin bad++; $display("FAIL early_out0 %h/%h op%0d: got %h want %h", a, b, op, out0, old); end
        wait_edge(s + 34);
        total++; if (out0 !== exp) begin bad++; $display("FAIL result %h/%h op%0d: got %h want %h", a, b, op, out0, exp); end
        wait_done(60, de);
        total++; if (de != s + 40) begin bad++; $display("FAIL done_edge %h/%h: got %0d want %0d", a, b, de, s + 40); end
    endtask

    task automatic test_basic();
        test_one_div(32'd100, 32'd7, 1'b0);
        test_one_div(32'd100, 32'd7, 1'b1);
    endtask

    task automatic test_signs();
        test_one_div(-32'sd100, 32'd7, 1'b0);
        test_one_div(-32'sd100, 32'd7, 1'b1);
        test_one_div(32'd100, -32'sd7, 1'b0);
        test_one_div(32'd100, -32'sd7, 1'b1);
        test_one_div(-32'sd100, -32'sd7, 1'b0);
        test_one_div(-32'sd100, -32'sd7, 1'b1);
    endtask

    task automatic test_special();
        test_one_div(32'd55, 32'd0, 1'b0);
        test_one_div(32'd55, 32'd0, 1'b1);
        test_one_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        test_one_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_zero_iter();
        logic [31:0] old;
        int r;
        rand_ops = 1'b0;
        @(negedge clk);
        in0 = 32'd12345; in1 = 32'd1; opcode = 1'b0;
        old = out0;
        pulse_run(32'd5, 10'd0, 10'd40, r);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_iter_run_clears: got %b want 0", done); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_iter_done: got %b want 1", done); end
        wait_edge(r + 60);
        total++; if (out0 !== old) begin bad++; $display("FAIL zero_iter_out0: got %h want %h", out0, old); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_iter_done_hold: got %b want 1", done); end
    endtask

    task automatic check_run(input int r, input int d0, input int it, input int p, input string tag);
        int last, de_exp, de;
        bit ovr;
        logic [31:0] exp;
        model_run(r + d0 + 3, it, p, last, ovr, de_exp);
        wait_done(de_exp - r + 20, de);
        exp = ref_div(log0[last % 1024], log1[last % 1024], logop[last % 1024]);
        total++; if (de != de_exp) begin bad++; $display("FAIL %s done_edge: got %0d want %0d", tag, de, de_exp); end
        total++; if (out0 !== exp) begin bad++; $display("FAIL %s out0: got %h want %h", tag, out0, exp); end
        total++; if (overrun !== ovr) begin bad++; $display("FAIL %s overrun: got %b want %b", tag, overrun, ovr); end
    endtask

    task automatic test_overrun();
        int r;
        rand_ops = 1'b1;
        pulse_run(32'd0, 10'd3, 10'd10, r);
        check_run(r, 0, 3, 10, "overrun_p10");
        pulse_run(32'd0, 10'd1, 10'd40, r);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL run_clears_overrun: got %b want 0", overrun); end
        check_run(r, 0, 1, 40, "after_overrun");
    endtask

    task automatic test_random();
        int r, d0, it, p;
        rand_ops = 1'b1;
        for (int n = 0; n < 8; n++) begin
            d0 = $urandom_range(0, 5);
            it = $urandom_range(1, 4);
            p  = $urandom_range(0, 45);
            pulse_run(32'(d0), 10'(it), 10'(p), r);
            check_run(r, d0, it, p, $sformatf("rand%0d_d%0d_i%0d_p%0d", n, d0, it, p));
        end
    endtask

    task automatic test_reset_mid();
        int r, s;
        rand_ops = 1'b0;
        @(negedge clk);
        in0 = 32'd1000; in1 = 32'd3; opcode = 1'b0;
        pulse_run(32'd0, 10'd2, 10'd5, r);
        s = r + 3;
        wait_edge(s + 10);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL mid_overrun_set: got %b want 1", overrun); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL async_rst_done: got %b want 0", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL async_rst_overrun: got %b want 0", overrun); end
        total++; if (out0 !== 32'h0) begin bad++; $display("FAIL async_rst_out0: got %h want 0", out0); end
        @(negedge clk) rst_n = 1'b1;
        test_one_div(-32'sd1000, 32'd3, 1'b0);
        test_one_div(-32'sd1000, 32'd3, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_special();
        test_zero_iter();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
